// File: rtl/noncoh_normalizer.sv
// noncoh_normalizer: converts wide non-coherent magnitudes into an 8-bit
// mantissa plus a 4-bit block exponent, and tags each sample with its
// code/frequency position for the downstream peak sorter.
// Two register stages: stage 1 finds the leading one and latches the
// position; stage 2 applies the running block exponent.
// Optional build macro: NONCOH_ROUND_EN selects round-half-up with
// saturation to 255 instead of plain truncation.
module noncoh_normalizer #(
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [14:0]          code_len,
    input  logic [8:0]           freq_count,
    input  logic [ACC_WIDTH-1:0] acc_data,
    input  logic                 acc_valid,
    output logic [7:0]           input_amp,
    output logic [3:0]           input_exp,
    output logic [14:0]          code_pos,
    output logic [8:0]           freq_pos,
    output logic                 peak_valid,
    output logic                 round_done,
    output logic                 overflow
);

    // Position counters and round state
    logic [14:0] code_cnt_q;
    logic [8:0]  freq_cnt_q;
    logic        done_q;
    logic        overflow_q;

    // Stage 1
    logic                 s1_vld_q;
    logic [ACC_WIDTH-1:0] s1_data_q;
    logic [14:0]          s1_code_q;
    logic [8:0]           s1_freq_q;
    logic [3:0]           s1_need_q;
    logic                 s1_last_q;

    // Stage 2 / outputs
    logic [3:0]  block_exp_q;
    logic [7:0]  amp_q;
    logic [3:0]  exp_q;
    logic [14:0] code_pos_q;
    logic [8:0]  freq_pos_q;
    logic        peak_valid_q;
    logic        round_done_q;

    logic [4:0]  msb;
    logic [3:0]  need_exp;
    logic [14:0] len_eff;
    logic [8:0]  fcnt_eff;
    logic        code_end;
    logic        freq_end;
    logic        accept;

    logic [3:0]         new_exp;
    logic [ACC_WIDTH:0] rnd_inc;
    logic [ACC_WIDTH:0] shifted;
    logic [7:0]         amp_d;

    // Leading-one detect and the exponent this sample alone would need
    always_comb begin
        msb = 5'd0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (acc_data[i]) msb = 5'(i);
        end
        need_exp = (msb > 5'd7) ? 4'(msb - 5'd7) : 4'd0;
    end

    // Zero lengths behave as one; >= keeps counters bounded if lengths shrink
    always_comb begin
        len_eff  = (code_len == 15'd0) ? 15'd1 : code_len;
        fcnt_eff = (freq_count == 9'd0) ? 9'd1 : freq_count;
        code_end = (code_cnt_q >= len_eff - 15'd1);
        freq_end = (freq_cnt_q >= fcnt_eff - 9'd1);
        accept   = acc_valid && !done_q;
    end

    // Stage 1 capture, position counters, done/overflow state
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            code_cnt_q <= '0;
            freq_cnt_q <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_data_q  <= '0;
            s1_code_q  <= '0;
            s1_freq_q  <= '0;
            s1_need_q  <= '0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            if (acc_valid && done_q) overflow_q <= 1'b1;
            if (accept) begin
                s1_data_q <= acc_data;
                s1_code_q <= code_cnt_q;
                s1_freq_q <= freq_cnt_q;
                s1_need_q <= need_exp;
                s1_last_q <= code_end && freq_end;
                if (code_end) begin
                    code_cnt_q <= '0;
                    if (freq_end) begin
                        freq_cnt_q <= '0;
                        done_q     <= 1'b1;
                    end else begin
                        freq_cnt_q <= freq_cnt_q + 9'd1;
                    end
                end else begin
                    code_cnt_q <= code_cnt_q + 15'd1;
                end
            end
        end
    end

    // Block exponent never decreases; mantissa scaled by the updated exponent
    always_comb begin
        new_exp = (s1_need_q > block_exp_q) ? s1_need_q : block_exp_q;
        rnd_inc = '0;
`ifdef NONCOH_ROUND_EN
        if (new_exp != 4'd0) rnd_inc = (ACC_WIDTH+1)'(1) << (new_exp - 4'd1);
`endif
        shifted = ({1'b0, s1_data_q} + rnd_inc) >> new_exp;
        // Truncation always fits in 8 bits; only rounding can carry past 255
        amp_d   = (|shifted[ACC_WIDTH:8]) ? 8'hFF : shifted[7:0];
    end

    // Stage 2 output register; data fields hold while idle
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            block_exp_q  <= '0;
            amp_q        <= '0;
            exp_q        <= '0;
            code_pos_q   <= '0;
            freq_pos_q   <= '0;
            peak_valid_q <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            peak_valid_q <= s1_vld_q;
            round_done_q <= s1_vld_q && s1_last_q;
            if (s1_vld_q) begin
                block_exp_q <= new_exp;
                amp_q       <= amp_d;
                exp_q       <= new_exp;
                code_pos_q  <= s1_code_q;
                freq_pos_q  <= s1_freq_q;
            end
        end
    end

    assign input_amp  = amp_q;
    assign input_exp  = exp_q;
    assign code_pos   = code_pos_q;
    assign freq_pos   = freq_pos_q;
    assign peak_valid = peak_valid_q;
    assign round_done = round_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_noncoh_normalizer.sv
// Scoreboard bench for noncoh_normalizer: stimulus pushes hand-computed
// expected outputs; a negedge monitor pops and compares on peak_valid.
module tb_noncoh_normalizer;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst, clear, acc_valid;
    logic [14:0]   code_len;
    logic [8:0]    freq_count;
    logic [AW-1:0] acc_data;
    logic [7:0]    input_amp;
    logic [3:0]    input_exp;
    logic [14:0]   code_pos;
    logic [8:0]    freq_pos;
    logic          peak_valid, round_done, overflow;

    typedef struct {
        logic [7:0]  amp;
        logic [3:0]  ex;
        logic [14:0] code;
        logic [8:0]  freq;
        logic        last;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    noncoh_normalizer #(.ACC_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .code_len(code_len),
        .freq_count(freq_count), .acc_data(acc_data), .acc_valid(acc_valid),
        .input_amp(input_amp), .input_exp(input_exp), .code_pos(code_pos),
        .freq_pos(freq_pos), .peak_valid(peak_valid), .round_done(round_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every peak_valid must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (peak_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_peak_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("amp", int'(input_amp), int'(e.amp));
                    chk("exp", int'(input_exp), int'(e.ex));
                    chk("code_pos", int'(code_pos), int'(e.code));
                    chk("freq_pos", int'(freq_pos), int'(e.freq));
                    chk("round_done", int'(round_done), int'(e.last));
                end
            end else if (round_done) begin
                chk("round_done_without_valid", 1, 0);
            end
        end
    end

    // Present one sample this cycle and leave the bench one cycle later
    task automatic send(input logic [AW-1:0] d, input logic push,
                        input logic [7:0] amp, input logic [3:0] ex,
                        input int code, input int freq, input logic last);
        exp_t e;
        acc_data  = d;
        acc_valid = 1'b1;
        if (push) begin
            e.amp = amp; e.ex = ex; e.code = 15'(code); e.freq = 9'(freq); e.last = last;
            q.push_back(e);
        end
        @(posedge clk); #1;
        acc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
        chk(name, q.size(), 0);
        idle(2);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; acc_valid = 1'b0; acc_data = '0;
        code_len = 15'd4; freq_count = 9'd2;
        idle(3);
        @(negedge clk);
        chk("rst_amp", int'(input_amp), 0);
        chk("rst_exp", int'(input_exp), 0);
        chk("rst_code", int'(code_pos), 0);
        chk("rst_freq", int'(freq_pos), 0);
        chk("rst_pv", int'(peak_valid), 0);
        chk("rst_rd", int'(round_done), 0);
        chk("rst_ovf", int'(overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Full round of 8, back-to-back
        for (int i = 0; i < 8; i++) send(16'd100, 1, 8'd100, 4'd0, i % 4, i / 4, i == 7);
        drain("round1_drain");
        chk("ovf_before_extra", int'(overflow), 0);

        // Sample after round completion is dropped and flags overflow
        send(16'd77, 0, 0, 0, 0, 0, 0);
        idle(3);
        chk("ovf_set", int'(overflow), 1);
        idle(4);
        chk("ovf_held", int'(overflow), 1);
        do_clear();
        chk("ovf_cleared", int'(overflow), 0);

        // Exponent growth and non-decrease
        send(16'h00FF, 1, 8'd255, 4'd0, 0, 0, 0);
        send(16'h0100, 1, 8'd128, 4'd1, 1, 0, 0);
        send(16'h0040, 1, 8'd32,  4'd1, 2, 0, 0);
        drain("exp_grow_drain");
        do_clear();

        // Jump of more than one exponent step
        send(16'h0010, 1, 8'd16,  4'd0, 0, 0, 0);
        send(16'hFFFF, 1, 8'd255, 4'd8, 1, 0, 0);
        drain("exp_jump_drain");
        // Outputs hold while idle
        chk("hold_amp", int'(input_amp), 255);
        chk("hold_exp", int'(input_exp), 8);
        chk("hold_code", int'(code_pos), 1);

        // clear with acc_valid, then clear while samples are in flight
        acc_data = 16'hFFFF; acc_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        send(16'hFFFF, 0, 0, 0, 0, 0, 0);
        acc_data = 16'hFFFF; acc_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        acc_valid = 1'b0; clear = 1'b0;
        idle(3);
        send(16'd50, 1, 8'd50, 4'd0, 0, 0, 0);
        drain("post_clear_drain");
        do_clear();

        // Rounding vs truncation
`ifdef NONCOH_ROUND_EN
        send(16'h017F, 1, 8'd192, 4'd1, 0, 0, 0);
`else
        send(16'h017F, 1, 8'd191, 4'd1, 0, 0, 0);
`endif
        send(16'h01FF, 1, 8'd255, 4'd1, 1, 0, 0);
        drain("round_drain");
        do_clear();

        // freq_count of zero acts as one bin: round is code_len samples
        code_len = 15'd2; freq_count = 9'd0;
        send(16'd5, 1, 8'd5, 4'd0, 0, 0, 0);
        send(16'd6, 1, 8'd6, 4'd0, 1, 0, 1);
        drain("fc0_drain");
        send(16'd7, 0, 0, 0, 0, 0, 0);
        idle(3);
        chk("fc0_ovf", int'(overflow), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/noncoh_normalizer.md
Name: noncoh_normalizer

Overview:
Sits directly upstream of the acquisition peak sorter. It converts wide unsigned non-coherent accumulation magnitudes into 8-bit mantissa plus 4-bit block exponent, and tags each sample with its code/frequency position. Outputs drive the sorter's input_amp/input_exp/code_pos/freq_pos/peak_valid directly. The block exponent is monotonic non-decreasing within a search round.

Parameters:
ACC_WIDTH, 16, width of incoming magnitude; legal range 9..23 so that the exponent fits in 4 bits.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active high
clear  input  1  start of new search round; flushes pipeline, counters, exponent
code_len  input  15  code positions per frequency bin (N gives positions 0..N-1); 0 treated as 1
freq_count  input  9  frequency bins per round (M gives bins 0..M-1); 0 treated as 1
acc_data  input  ACC_WIDTH  non-coherent magnitude sample
acc_valid  input  1  acc_data valid this cycle
input_amp  output  8  normalized mantissa
input_exp  output  4  block exponent applied to input_amp
code_pos  output  15  code position of output sample
freq_pos  output  9  frequency bin of output sample
peak_valid  output  1  output sample valid, one-cycle pulse per sample
round_done  output  1  one-cycle pulse coincident with the last sample of the round
overflow  output  1  sticky; sample arrived after round complete

Behaviour:
- Reset/clear: all outputs 0; internal code/freq counters 0; block exponent 0; pipeline valids 0; done-state cleared.
- rst has priority over clear; clear has priority over acc_valid. A sample presented with clear is dropped. Samples already in the pipeline are discarded, with no peak_valid.
- Stage 1 (register on acc_valid):
  - latch acc_data and the current code/freq counters;
  - compute msb = index of leading one (0 if acc_data==0);
  - need_exp = msb>7 ? msb-7 : 0.
- Position counters advance on each accepted sample:
  - code counter increments; at code_len-1 it wraps to 0 and the freq counter increments;
  - at code_len-1 and freq_count-1, set the done state and flag the sample as last.
- Stage 2:
  - new_exp = max(block_exp, need_exp); block_exp <= new_exp;
  - input_amp = data >> new_exp (truncate); the result fits in 8 bits by construction;
  - input_exp = new_exp; positions pass through;
  - peak_valid <= stage-1 valid; round_done <= stage-1 valid && last.
- Latency: acc_valid at cycle T gives peak_valid at T+2. Full throughput of 1 sample/cycle; back-to-back samples use the exponent updated by the immediately preceding sample with no bubble.
- Exponent jumps of more than 1 are reported as-is.
- In the done state, acc_valid samples are dropped and overflow is set (sticky until clear/rst). Counters hold.
- code_len/freq_count are sampled continuously and must be static during a round; changes mid-round are undefined.
- Wrap: freq_pos never exceeds freq_count-1; code_pos never exceeds code_len-1.
- When idle, outputs hold their last values; only peak_valid and round_done return to 0.

Optional Feature:
NONCOH_ROUND_EN
- Defined: when new_exp>0, input_amp = (data + (1<<(new_exp-1))) >> new_exp, saturated to 255. Latency is unchanged.
- Undefined: pure truncation, as above.

Test Plan:
1. rst, then code_len=4, freq_count=2; 8 samples acc_data=100 back-to-back -> peak_valid T+2..T+9; (freq,code) sequence 0/0..0/3, 1/0..1/3; input_amp=100, input_exp=0; round_done only with the 8th.
2. Samples 0x00FF then 0x0100 then 0x0040 -> amp/exp = 255/0, 128/1, 32/1; exponent never decreases.
3. Sample 0xFFFF after 0x0010 (ACC_WIDTH=16) -> second output exp=8, amp=255; first output amp=16, exp=0.
4. Complete round of 8, then a 9th acc_valid -> no peak_valid, overflow=1 and held. clear -> overflow=0, counters restart at 0/0.
5. clear asserted with acc_valid, and again while 2 samples are in flight -> no peak_valid for any of them; next sample reports code_pos=0, freq_pos=0, exp=0.
6. NONCOH_ROUND_EN defined: sample 0x017F -> exp=1, amp=192 (truncating build gives 191); sample 0x01FF -> amp saturates at 255, exp=1.
